// File: rtl/mul_accum_pkg.sv
// Shared types and constants for the mul_accum dot-product accumulator.
package mul_accum_pkg;

  localparam int unsigned Q015_W = 16;

  localparam logic [Q015_W-1:0] Q015_MAX = 16'h7FFF;
  localparam logic [Q015_W-1:0] Q015_MIN = 16'h8000;

  typedef enum logic [1:0] {
    PREC_Q03  = 2'b00,
    PREC_Q07  = 2'b01,
    PREC_Q015 = 2'b10
  } prec_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ACCUM = 2'b01,
    S_DONE  = 2'b10
  } state_e;

  // Reserved encoding 2'b11 behaves as Q0.15.
  function automatic prec_e decode_prec(input logic [1:0] sel);
    prec_e p;
    case (sel)
      2'b00:   p = PREC_Q03;
      2'b01:   p = PREC_Q07;
      default: p = PREC_Q015;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/mul_accum_prec_align.sv
// Selects the product stream for the active precision and aligns it to a
// sign-extended Q0.15 term of accumulator width.
module prec_align
  import mul_accum_pkg::*;
#(
  parameter int unsigned ACC_W = 32
) (
  input  prec_e             prec,
  input  logic [3:0]        prod4_in,
  input  logic              prod4_valid,
  input  logic [7:0]        prod8_in,
  input  logic              prod8_valid,
  input  logic [15:0]       prod16_in,
  input  logic              prod16_valid,
  output logic [ACC_W-1:0]  term_c,
  output logic              valid_c
);

  logic [Q015_W-1:0] aligned;

  always_comb begin
    aligned = '0;
    valid_c = 1'b0;
    case (prec)
      PREC_Q03: begin
        aligned = {prod4_in, 12'h000};
        valid_c = prod4_valid;
      end
      PREC_Q07: begin
        aligned = {prod8_in, 8'h00};
        valid_c = prod8_valid;
      end
      default: begin
        aligned = prod16_in;
        valid_c = prod16_valid;
      end
    endcase
  end

  assign term_c = {{(ACC_W-Q015_W){aligned[Q015_W-1]}}, aligned};

endmodule

// File: rtl/mul_accum.sv
// Dot-product accumulator: sums vec_len aligned products and presents a
// Q0.15 result with an out-of-range flag. Define MUL_ACCUM_SAT_EN to clamp
// out-of-range results; otherwise the low 16 bits of the sum are returned.
module mul_accum
  import mul_accum_pkg::*;
#(
  parameter int unsigned ACC_W = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic [1:0]       prec_sel,
  input  logic [3:0]       prod4_in,
  input  logic             prod4_valid,
  input  logic [7:0]       prod8_in,
  input  logic             prod8_valid,
  input  logic [15:0]      prod16_in,
  input  logic             prod16_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      acc_out,
  output logic             acc_valid,
  output logic             sat,
  output logic             drop_err
);

  state_e             state_q, state_d;
  prec_e              prec_q, prec_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        acc_out_d;
  logic               acc_valid_d, sat_d, drop_err_d, busy_d;

  logic [ACC_W-1:0]   term_c;
  logic               sel_valid_c;
  logic [ACC_W-1:0]   sum_c;
  logic [LEN_W-1:0]   cnt_inc_c;
  logic               sat_c;
  logic [15:0]        result_c;

  prec_align #(
    .ACC_W (ACC_W)
  ) u_align (
    .prec         (prec_q),
    .prod4_in     (prod4_in),
    .prod4_valid  (prod4_valid),
    .prod8_in     (prod8_in),
    .prod8_valid  (prod8_valid),
    .prod16_in    (prod16_in),
    .prod16_valid (prod16_valid),
    .term_c       (term_c),
    .valid_c      (sel_valid_c)
  );

  assign sum_c     = acc_q + term_c;
  assign cnt_inc_c = cnt_q + LEN_W'(1);

  // In Q0.15 range iff bits [ACC_W-1:15] are a pure sign extension.
  assign sat_c = !((sum_c[ACC_W-1:15] == '0) || (sum_c[ACC_W-1:15] == '1));

`ifdef MUL_ACCUM_SAT_EN
  assign result_c = sat_c ? (sum_c[ACC_W-1] ? Q015_MIN : Q015_MAX) : sum_c[15:0];
`else
  assign result_c = sum_c[15:0];
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    prec_d      = prec_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    acc_out_d   = acc_out;
    acc_valid_d = acc_valid;
    sat_d       = sat;
    drop_err_d  = drop_err;

    case (state_q)
      S_IDLE: begin
        if (sel_valid_c) drop_err_d = 1'b1;
        if (start) begin
          prec_d     = decode_prec(prec_sel);
          len_d      = vec_len;
          acc_d      = '0;
          cnt_d      = '0;
          drop_err_d = 1'b0;
          if (vec_len == '0) begin
            state_d     = S_DONE;
            acc_out_d   = '0;
            sat_d       = 1'b0;
            acc_valid_d = 1'b1;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (sel_valid_c) begin
          acc_d = sum_c;
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == len_q) begin
            state_d     = S_DONE;
            acc_out_d   = result_c;
            sat_d       = sat_c;
            acc_valid_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (sel_valid_c) drop_err_d = 1'b1;
        if (out_ready) begin
          state_d     = S_IDLE;
          acc_valid_d = 1'b0;
          sat_d       = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        acc_valid_d = 1'b0;
        sat_d       = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      prec_q    <= PREC_Q015;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      busy      <= 1'b0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      sat       <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prec_q    <= prec_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      busy      <= busy_d;
      acc_out   <= acc_out_d;
      acc_valid <= acc_valid_d;
      sat       <= sat_d;
      drop_err  <= drop_err_d;
    end
  end

endmodule

// File: tb/tb_mul_accum.sv
// Directed self-checking bench for mul_accum (default and MUL_ACCUM_SAT_EN builds).
module tb_mul_accum;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  vec_len;
  logic [1:0]  prec_sel;
  logic [3:0]  prod4_in;
  logic        prod4_valid;
  logic [7:0]  prod8_in;
  logic        prod8_valid;
  logic [15:0] prod16_in;
  logic        prod16_valid;
  logic        out_ready;
  logic        busy;
  logic [15:0] acc_out;
  logic        acc_valid;
  logic        sat;
  logic        drop_err;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MUL_ACCUM_SAT_EN
  localparam logic [15:0] EXP_POS_OVF  = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF  = 16'h8000;
  localparam logic [15:0] EXP_Q03_OVF  = 16'h7FFF;
`else
  localparam logic [15:0] EXP_POS_OVF  = 16'hE000;
  localparam logic [15:0] EXP_NEG_OVF  = 16'h7000;
  localparam logic [15:0] EXP_Q03_OVF  = 16'h8000;
`endif

  mul_accum #(
    .ACC_W (32),
    .LEN_W (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .vec_len      (vec_len),
    .prec_sel     (prec_sel),
    .prod4_in     (prod4_in),
    .prod4_valid  (prod4_valid),
    .prod8_in     (prod8_in),
    .prod8_valid  (prod8_valid),
    .prod16_in    (prod16_in),
    .prod16_valid (prod16_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .acc_out      (acc_out),
    .acc_valid    (acc_valid),
    .sat          (sat),
    .drop_err     (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, acc_valid, sat, drop_err, acc_out} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b valid=%b sat=%b drop=%b out=%h, want all 0",
               busy, acc_valid, sat, drop_err, acc_out);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_drop_idle();
    prod16_in = 16'h1234; prod16_valid = 1'b1;
    step();
    prod16_valid = 1'b0;
    n_tests++;
    if (drop_err !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_idle: got drop_err=%b, want 1", drop_err);
    end
  endtask

  task automatic test_accum_q015();
    start = 1'b1; vec_len = 8'd3; prec_sel = 2'b10;
    step();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || acc_valid !== 1'b0 || drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL accum_start: got busy=%b valid=%b drop=%b, want 1 0 0", busy, acc_valid, drop_err);
    end
    prod16_valid = 1'b1;
    prod16_in = 16'h4000; step();
    prod16_in = 16'h2000; step();
    n_tests++;
    if (acc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL accum_early_valid: got acc_valid=%b, want 0", acc_valid);
    end
    prod16_in = 16'h1000; step();
    prod16_valid = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b1 || acc_out !== 16'h7000 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL accum_result: got valid=%b out=%h sat=%b, want 1 7000 0", acc_valid, acc_out, sat);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL accum_release: got valid=%b busy=%b, want 0 0", acc_valid, busy);
    end
  endtask

  task automatic test_saturation();
    start = 1'b1; vec_len = 8'd2; prec_sel = 2'b10;
    step();
    start = 1'b0;
    prod16_valid = 1'b1;
    prod16_in = 16'h7000; step();
    prod16_in = 16'h7000; step();
    prod16_valid = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b1 || sat !== 1'b1 || acc_out !== EXP_POS_OVF) begin
      n_fail++;
      $display("FAIL sat_pos: got valid=%b out=%h sat=%b, want 1 %h 1", acc_valid, acc_out, sat, EXP_POS_OVF);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    // Reserved prec_sel 11 behaves as Q0.15; negative overflow.
    start = 1'b1; vec_len = 8'd2; prec_sel = 2'b11;
    step();
    start = 1'b0;
    prod16_valid = 1'b1;
    prod16_in = 16'h8000; step();
    prod16_in = 16'hF000; step();
    prod16_valid = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b1 || sat !== 1'b1 || acc_out !== EXP_NEG_OVF) begin
      n_fail++;
      $display("FAIL sat_neg: got valid=%b out=%h sat=%b, want 1 %h 1", acc_valid, acc_out, sat, EXP_NEG_OVF);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_prec_q07();
    start = 1'b1; vec_len = 8'd2; prec_sel = 2'b01;
    step();
    start = 1'b0;
    prod8_valid = 1'b1; prod16_valid = 1'b1; prod16_in = 16'h7FFF;
    prod8_in = 8'h40; step();
    prod8_valid = 1'b0; prod16_valid = 1'b1; step();
    prod8_valid = 1'b1; prod16_valid = 1'b0;
    prod8_in = 8'hE0; step();
    prod8_valid = 1'b0; prod16_valid = 1'b1; step();
    prod16_valid = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b1 || acc_out !== 16'h2000 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL q07_result: got valid=%b out=%h sat=%b, want 1 2000 0", acc_valid, acc_out, sat);
    end
    n_tests++;
    if (drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL q07_drop: got drop_err=%b, want 0", drop_err);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_zero_len_hold();
    start = 1'b1; vec_len = 8'd0; prec_sel = 2'b10;
    step();
    start = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b1 || acc_out !== 16'h0000 || sat !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_len: got valid=%b out=%h sat=%b busy=%b, want 1 0000 0 1",
               acc_valid, acc_out, sat, busy);
    end
    prod16_in = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      prod16_valid = (i % 2 == 0);
      step();
      n_tests++;
      if (acc_valid !== 1'b1 || acc_out !== 16'h0000 || sat !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_cycle%0d: got valid=%b out=%h sat=%b, want 1 0000 0", i, acc_valid, acc_out, sat);
      end
    end
    prod16_valid = 1'b0;
    n_tests++;
    if (drop_err !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_drop: got drop_err=%b, want 1", drop_err);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b0 || drop_err !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release: got valid=%b drop=%b, want 0 1", acc_valid, drop_err);
    end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; vec_len = 8'd4; prec_sel = 2'b00;
    step();
    start = 1'b0;
    n_tests++;
    if (drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL start_clears_drop: got drop_err=%b, want 0", drop_err);
    end
    prod4_valid = 1'b1; prod4_in = 4'h3;
    step(); step();
    prod4_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, acc_valid, sat, drop_err, acc_out} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b valid=%b sat=%b drop=%b out=%h, want all 0",
               busy, acc_valid, sat, drop_err, acc_out);
    end
    step();
    rst_n = 1'b1;
    start = 1'b1; vec_len = 8'd2; prec_sel = 2'b00;
    step();
    start = 1'b0;
    prod4_valid = 1'b1; prod4_in = 4'h4;
    step(); step();
    prod4_valid = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b1 || sat !== 1'b1 || acc_out !== EXP_Q03_OVF) begin
      n_fail++;
      $display("FAIL q03_after_reset: got valid=%b out=%h sat=%b, want 1 %h 1", acc_valid, acc_out, sat, EXP_Q03_OVF);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    start = 1'b1; vec_len = 8'd2; prec_sel = 2'b00;
    step();
    // start during ACCUM must be ignored
    start = 1'b1; vec_len = 8'd0;
    prod4_valid = 1'b1; prod4_in = 4'h9; step();
    start = 1'b0;
    prod4_in = 4'h2; step();
    prod4_valid = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b1 || acc_out !== 16'hB000 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_neg: got valid=%b out=%h sat=%b, want 1 b000 0", acc_valid, acc_out, sat);
    end
    // start during DONE must be ignored as well
    out_ready = 1'b1; start = 1'b1; vec_len = 8'd1; prec_sel = 2'b01;
    step();
    out_ready = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: got valid=%b busy=%b, want 0 0", acc_valid, busy);
    end
    step();
    start = 1'b0;
    prod8_valid = 1'b1; prod8_in = 8'h80; step();
    prod8_valid = 1'b0;
    n_tests++;
    if (acc_valid !== 1'b1 || acc_out !== 16'h8000 || sat !== 1'b0 || drop_err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: got valid=%b out=%h sat=%b drop=%b, want 1 8000 0 0",
               acc_valid, acc_out, sat, drop_err);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_len = '0; prec_sel = 2'b00;
    prod4_in = '0; prod4_valid = 1'b0;
    prod8_in = '0; prod8_valid = 1'b0;
    prod16_in = '0; prod16_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    test_reset();
    test_drop_idle();
    test_accum_q015();
    test_saturation();
    test_prec_q07();
    test_zero_len_hold();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_accum.md
MUL_ACCUM -- requirements
Module: mul_accum

Interface
REQ-001 SHALL have parameter ACC_W, default 32, signed accumulator width; legal only if ACC_W >= 16+LEN_W.
REQ-002 SHALL have parameter LEN_W, default 8, width of vector-length field.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  begin a new dot-product vector.
REQ-006 SHALL have port vec_len  input  LEN_W  number of products in vector, sampled with start.
REQ-007 SHALL have port prec_sel  input  2  00=Q0.3, 01=Q0.7, 10=Q0.15, 11=reserved (treated as 10), sampled with start.
REQ-008 SHALL have ports prod4_in/prod4_valid  input  4/1  Q0.3 product stream from upstream multiplier.
REQ-009 SHALL have ports prod8_in/prod8_valid  input  8/1  Q0.7 product stream.
REQ-010 SHALL have ports prod16_in/prod16_valid  input  16/1  Q0.15 product stream.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port busy  output  1  high in ACCUM or DONE.
REQ-013 SHALL have port acc_out  output  16  Q0.15 two's-complement dot-product result.
REQ-014 SHALL have port acc_valid  output  1  acc_out valid, held until out_ready.
REQ-015 SHALL have port sat  output  1  final sum outside Q0.15 range, valid with acc_valid.
REQ-016 SHALL have port drop_err  output  1  sticky: a selected-stream product arrived while not in ACCUM.

Function
REQ-017 SHALL implement FSM IDLE, ACCUM, DONE; start ignored outside IDLE.
REQ-018 IDLE + start, vec_len!=0 -> ACCUM next cycle; accumulator and count cleared; prec_sel latched.
REQ-019 IDLE + start, vec_len==0 -> DONE next cycle with acc_out=0x0000, sat=0.
REQ-020 In ACCUM only the stream chosen by latched prec_sel SHALL be consumed; other valids ignored, never flagged.
REQ-021 Each consumed product SHALL be treated as two's complement, left-aligned to Q0.15 (Q0.3 <<12, Q0.7 <<8), sign-extended to ACC_W and added; count increments.
REQ-022 On the cycle the vec_len-th product is consumed, FSM SHALL enter DONE next cycle with acc_valid=1 and acc_out registered (latency 1 cycle after last product).
REQ-023 sat SHALL be 1 iff final sum > 0x7FFF or < -0x8000 (as Q0.15 integer).
REQ-024 In DONE, acc_valid, acc_out, sat SHALL hold stable until out_ready=1; that cycle -> IDLE, acc_valid low next cycle.
REQ-025 Products on the selected stream while in IDLE or DONE SHALL be discarded and set drop_err; drop_err cleared only by reset or by start accepted in IDLE.
REQ-026 No input backpressure; one product per cycle sustained.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, accumulator/count 0, busy=0, acc_out=0x0000, acc_valid=0, sat=0, drop_err=0, including mid-ACCUM or mid-DONE; partial sum discarded.

Configuration
REQ-028 With MUL_ACCUM_SAT_EN defined, out-of-range sums SHALL clamp to 0x7FFF / 0x8000.
REQ-029 Without MUL_ACCUM_SAT_EN, acc_out SHALL be the low 16 bits of the sum (wrap); sat flag still reported.

Structure
REQ-030 Shared package mul_accum_pkg SHALL hold prec_e enum (PREC_Q03, PREC_Q07, PREC_Q015), state_e enum, Q015_MAX=0x7FFF, Q015_MIN=0x8000.
REQ-031 Alignment SHALL be a combinational sub-module prec_align (prec_e + three product inputs -> ACC_W signed aligned term + selected valid).

Verification
REQ-032 prec=10, vec_len=3, prod16 0x4000,0x2000,0x1000 back-to-back -> acc_out=0x7000, sat=0, acc_valid one cycle after third product.
REQ-033 prec=10, vec_len=2, 0x7000,0x7000 -> sat=1; acc_out=0x7FFF with MUL_ACCUM_SAT_EN, 0xE000 without.
REQ-034 prec=01, vec_len=2, prod8 0x40,0xE0 -> acc_out=0x2000; concurrent prod16_valid pulses ignored, drop_err=0.
REQ-035 vec_len=0 start -> acc_valid next cycle, acc_out=0x0000; out_ready low 5 cycles with prod16_valid pulses -> output stable, drop_err=1.
REQ-036 prec=00, vec_len=4, rst_n low after 2 products -> all outputs 0 immediately; new start with prod4 0x4,0x4 (vec_len=2) -> acc_out=0x7FFF (SAT_EN), sat=1.
